// File: rtl/serial_add_ctrl_if.sv
// Requester-side bundle for serial_add_ctrl: start/operand request and the
// busy/done/result response.
interface serial_add_ctrl_if #(
  parameter int unsigned W = 8
);
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;

  modport master (
    output start, a, b, cin,
    input  busy, done, sum, cout
  );

  modport slave (
    input  start, a, b, cin,
    output busy, done, sum, cout
  );
endinterface

// File: rtl/serial_add_ctrl.sv
// Multi-cycle adder controller: one 2-bit ripple slice reused over W/2 cycles,
// LSB pair first, with the inter-slice carry held in a register.
module serial_add_ctrl #(
  parameter int unsigned W = 8
) (
  input  logic              clk,
  input  logic              rst_b,
  serial_add_ctrl_if.slave  bus
);
  localparam int unsigned Slices = W / 2;
  localparam int unsigned CntW   = (Slices > 1) ? $clog2(Slices) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(Slices - 1);

  if ((W < 2) || ((W % 2) != 0)) begin : gen_w_check
    $error("serial_add_ctrl: W must be even and >= 2");
  end

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e        state;
  logic [W-1:0]  sa;
  logic [W-1:0]  sb;
  logic [W-1:0]  acc;
  logic          c;
  logic [CntW-1:0] cnt;

  logic [2:0]    slice;
  logic [W-1:0]  acc_nxt;

  always_comb begin
    slice = {1'b0, sa[1:0]} + {1'b0, sb[1:0]} + {2'b00, c};
  end

  // Slice results enter at the top and shift down, so after W/2 steps the LSB pair is at bit 0.
  if (W == 2) begin : gen_acc_w2
    assign acc_nxt = slice[1:0];
  end else begin : gen_acc_wide
    assign acc_nxt = {slice[1:0], acc[W-1:2]};
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state    <= StIdle;
      sa       <= '0;
      sb       <= '0;
      acc      <= '0;
      c        <= 1'b0;
      cnt      <= '0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.sum  <= '0;
      bus.cout <= 1'b0;
    end else begin
      unique case (state)
        StIdle: begin
          if (bus.start) begin
            sa       <= bus.a;
            sb       <= bus.b;
            c        <= bus.cin;
            cnt      <= '0;
            acc      <= '0;
            bus.busy <= 1'b1;
            state    <= StRun;
          end
        end
        StRun: begin
          acc <= acc_nxt;
          sa  <= sa >> 2;
          sb  <= sb >> 2;
          c   <= slice[2];
          cnt <= cnt + 1'b1;
          if (cnt == LastCnt) begin
            bus.sum  <= acc_nxt;
            bus.cout <= slice[2];
            bus.busy <= 1'b0;
            bus.done <= 1'b1;
            state    <= StDone;
          end
        end
        StDone: begin
          bus.done <= 1'b0;
          state    <= StIdle;
        end
        default: begin
          bus.busy <= 1'b0;
          bus.done <= 1'b0;
          state    <= StIdle;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed bench for serial_add_ctrl: table of W=8 vectors, multi-cycle corner
// sequences, and exhaustive W=4 / W=2 instances.
module tb_serial_add_ctrl;
  logic clk;
  logic rst_b;
  int   checks;
  int   errors;

  serial_add_ctrl_if #(.W(8)) if8 ();
  serial_add_ctrl_if #(.W(4)) if4 ();
  serial_add_ctrl_if #(.W(2)) if2 ();

  serial_add_ctrl #(.W(8)) dut8 (.clk(clk), .rst_b(rst_b), .bus(if8));
  serial_add_ctrl #(.W(4)) dut4 (.clk(clk), .rst_b(rst_b), .bus(if4));
  serial_add_ctrl #(.W(2)) dut2 (.clk(clk), .rst_b(rst_b), .bus(if2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] sum;
    logic       cout;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // One W=8 operation; optionally re-pulses start (with zero operands) mid-RUN.
  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic cin,
                     input logic [7:0] esum, input logic ecout, input logic inject,
                     input string name);
    logic [7:0] prev_sum;
    int n;
    int pulses;
    @(negedge clk);
    prev_sum  = if8.sum;
    if8.a     = a;
    if8.b     = b;
    if8.cin   = cin;
    if8.start = 1'b1;
    @(negedge clk);
    if8.start = 1'b0;
    n = 1;
    chk({name, " busy1"}, 32'(if8.busy), 32'd1);
    while (!if8.done && n < 20) begin
      if (inject && n == 2) begin
        if8.start = 1'b1;
        if8.a     = 8'h00;
        if8.b     = 8'h00;
        if8.cin   = 1'b0;
      end else begin
        if8.start = 1'b0;
      end
      @(negedge clk);
      n++;
      if (n == 3) chk({name, " sum_held"}, 32'(if8.sum), 32'(prev_sum));
    end
    if8.start = 1'b0;
    chk({name, " latency"}, 32'(n), 32'd5);
    chk({name, " sum"}, 32'(if8.sum), 32'(esum));
    chk({name, " cout"}, 32'(if8.cout), 32'(ecout));
    chk({name, " busy_at_done"}, 32'(if8.busy), 32'd0);
    @(negedge clk);
    chk({name, " done_pulse"}, 32'(if8.done), 32'd0);
    if (inject) begin
      pulses = 0;
      for (int i = 0; i < 8; i++) begin
        @(negedge clk);
        if (if8.done) pulses++;
      end
      chk({name, " extra_done"}, 32'(pulses), 32'd0);
      chk({name, " sum_kept"}, 32'(if8.sum), 32'(esum));
    end
  endtask

  // One operation on the W=4 or W=2 instance.
  task automatic run_small(input int w, input logic [3:0] a, input logic [3:0] b,
                           input logic cin);
    logic [4:0] got;
    logic [4:0] exp;
    logic       d;
    int n;
    exp = {1'b0, a} + {1'b0, b} + {4'b0, cin};
    @(negedge clk);
    if (w == 4) begin
      if4.a = a; if4.b = b; if4.cin = cin; if4.start = 1'b1;
    end else begin
      if2.a = a[1:0]; if2.b = b[1:0]; if2.cin = cin; if2.start = 1'b1;
    end
    @(negedge clk);
    if4.start = 1'b0;
    if2.start = 1'b0;
    n = 1;
    d = (w == 4) ? if4.done : if2.done;
    while (!d && n < 12) begin
      @(negedge clk);
      n++;
      d = (w == 4) ? if4.done : if2.done;
    end
    got = (w == 4) ? {if4.cout, if4.sum} : {2'b00, if2.cout, if2.sum};
    chk($sformatf("w%0d latency", w), 32'(n), 32'(w / 2 + 1));
    chk($sformatf("w%0d %0h+%0h+%0b", w, a, b, cin), 32'(got), 32'(exp));
  endtask

  vec_t       vecs[10];
  logic [8:0] held_exp[18];
  int         dcount;

  initial begin
    checks = 0;
    errors = 0;
    rst_b  = 1'b0;
    if8.start = 1'b0; if8.a = '0; if8.b = '0; if8.cin = 1'b0;
    if4.start = 1'b0; if4.a = '0; if4.b = '0; if4.cin = 1'b0;
    if2.start = 1'b0; if2.a = '0; if2.b = '0; if2.cin = 1'b0;

    vecs[0] = '{8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
    vecs[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
    vecs[3] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
    vecs[4] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0};
    vecs[5] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
    vecs[6] = '{8'h12, 8'h34, 1'b1, 8'h47, 1'b0};
    vecs[7] = '{8'hAA, 8'h55, 1'b0, 8'hFF, 1'b0};
    vecs[8] = '{8'hAA, 8'h55, 1'b1, 8'h00, 1'b1};
    vecs[9] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0};

    #23;
    chk("rst busy", 32'(if8.busy), 32'd0);
    chk("rst done", 32'(if8.done), 32'd0);
    chk("rst sum", 32'(if8.sum), 32'd0);
    chk("rst cout", 32'(if8.cout), 32'd0);
    chk("rst w4 result", 32'({if4.cout, if4.sum}), 32'd0);
    @(negedge clk);
    rst_b = 1'b1;

    for (int i = 0; i < 10; i++) begin
      op8(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sum, vecs[i].cout, 1'b0,
          $sformatf("vec%0d", i));
    end

    // Restart attempt mid-RUN with zero operands must not disturb the result.
    op8(8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1, "ignore_start");

    // Asynchronous reset in the third RUN cycle.
    @(negedge clk);
    if8.a = 8'h33; if8.b = 8'h44; if8.cin = 1'b1; if8.start = 1'b1;
    @(negedge clk);
    if8.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2 rst_b = 1'b0;
    #1;
    chk("midrst busy", 32'(if8.busy), 32'd0);
    chk("midrst done", 32'(if8.done), 32'd0);
    chk("midrst sum", 32'(if8.sum), 32'd0);
    chk("midrst cout", 32'(if8.cout), 32'd0);
    @(negedge clk);
    rst_b = 1'b1;
    dcount = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (if8.done) dcount++;
    end
    chk("midrst no_done", 32'(dcount), 32'd0);
    op8(8'hC3, 8'h5E, 1'b1, 8'h22, 1'b1, 1'b0, "after_rst");

    // Start held high: accepts at k = 0, 6, 12; done after edges 4, 10, 16.
    @(negedge clk);
    for (int k = 0; k < 18; k++) begin
      if (k >= 1) begin
        chk($sformatf("held done k%0d", k - 1), 32'(if8.done),
            32'(((k - 1) % 6) == 4));
        if (((k - 1) % 6) == 4)
          chk($sformatf("held result k%0d", k - 1), 32'({if8.cout, if8.sum}),
              32'(held_exp[k - 5]));
      end
      if8.a     = 8'(k * 17 + 3);
      if8.b     = 8'(k * 29 + 250);
      if8.cin   = k[0];
      held_exp[k] = {1'b0, if8.a} + {1'b0, if8.b} + {8'b0, if8.cin};
      if8.start = 1'b1;
      @(negedge clk);
    end
    chk("held done k17", 32'(if8.done), 32'd0);
    if8.start = 1'b0;
    @(negedge clk);
    @(negedge clk);

    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        for (int c = 0; c < 2; c++)
          run_small(4, 4'(a), 4'(b), c[0]);

    for (int a = 0; a < 4; a++)
      for (int b = 0; b < 4; b++)
        for (int c = 0; c < 2; c++)
          run_small(2, 4'(a), 4'(b), c[0]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
